memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Sits between the per-CPU data-request side of the multi-CPU memory bus interface and the single-ported RAM.
- Consumes each CPU's dREN/dWEN/daddr/dstore and returns dwait/dload.
- Serialises requests onto one RAM port with round-robin fairness; exactly one CPU owns the RAM at a time.

Parameters:
- CPUS, 2, number of requesting CPUs (≥2)
- PTRW, $clog2(CPUS), width of owner/priority pointers

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- dREN  input  CPUS  per-CPU read request
- dWEN  input  CPUS  per-CPU write request
- daddr  input  CPUS×32  per-CPU word address
- dstore  input  CPUS×32  per-CPU write data
- dwait  output  CPUS  per-CPU wait, low only in the cycle the access completes
- dload  output  CPUS×32  per-CPU read data
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset is asynchronous and active-low; all state clears immediately on nRST low.
- Reset values: state=IDLE, owner=0, rr_ptr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=all 1s.
- req[i] = dREN[i] | dWEN[i].
- State IDLE:
  - RAM outputs are 0.
  - If any req, select the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … mod CPUS.
  - Register owner=i and go to GRANT at the next edge.
  - Grant latency is one cycle from request to ram enable.
- State GRANT:
  - ramaddr=daddr[owner] and ramstore=dstore[owner], combinational pass-through.
  - ramWEN=dWEN[owner]; ramREN=dREN[owner] & ~dWEN[owner], so write wins if both are asserted.
- GRANT with ramstate==ACCESS:
  - dwait[owner]=0 this cycle only.
  - Next edge: state→IDLE, rr_ptr→(owner+1) mod CPUS.
- GRANT with ramstate BUSY, FREE or ERROR:
  - All dwait stay 1; remain in GRANT.
  - ERROR is retried by continuing to hold the request.
- GRANT with req[owner]=0 (requester aborted):
  - ramREN=ramWEN=0 that cycle; no dwait drop.
  - →IDLE at the next edge; rr_ptr unchanged.
- dwait[i]=1 for every i≠owner at all times, and for owner at all times outside the ACCESS cycle.
- dload[i]=ramload for all i, broadcast. Read data is valid only where dwait[i]=0.
- CPUs must hold dREN/dWEN/daddr/dstore stable until their dwait falls. The arbiter does not latch address or data.
- There is at least one IDLE cycle between consecutive grants; the minimum access occupies 2 cycles (IDLE select + GRANT/ACCESS).
- Fairness: a continuously requesting CPU is granted within CPUS grants.
- Simultaneous requests in IDLE are resolved by rr_ptr only; fixed index order is never used.
- Reset asserted mid-GRANT: ramREN/ramWEN drop immediately; the in-flight access is discarded.
- Requests arriving while another CPU owns the RAM are ignored until IDLE; no queueing.
- Illegal ramstate encodings do not exist (2-bit full decode).

Test Plan:
- Single read: CPUS=2, CPU0 dREN=1, daddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 from cycle 1; dwait[0]=0 and dload[0]=0xDEADBEEF in the ACCESS cycle only; dwait[1]=1 throughout.
- Single write: CPU1 dWEN=1, daddr=0x80, dstore=0x12345678, ACCESS on first GRANT cycle -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait[1] low exactly one cycle; next state IDLE, rr_ptr=0.
- Contention: both CPUs request from reset, ACCESS every GRANT cycle -> grants alternate 0,1,0,1; each dwait falls every 4 cycles; neither is starved over 20 grants.
- Read+write same CPU: dREN[0]=dWEN[0]=1 -> ramWEN=1, ramREN=0.
- Abort: CPU0 granted, drops dREN before ACCESS -> ram enables 0 that cycle, return to IDLE, rr_ptr stays 0; a pending CPU1 request is granted next.
- Async reset: nRST low mid-GRANT with ramREN=1 -> ramREN=0 and dwait=2'b11 immediately, before any clock edge; after release, state=IDLE, rr_ptr=0.

Source files
------------

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose:
//   Round-robin arbiter between the per-CPU data request ports and a single
//   ported RAM. One CPU owns the RAM at a time. Address and store data are
//   passed straight through from the owner and are never latched, so each CPU
//   must hold its request stable until its dwait drops.
//
// Ports:
//   CLK       in   system clock, rising edge
//   nRST      in   asynchronous active-low reset
//   dREN      in   [CPUS]     per-CPU read request
//   dWEN      in   [CPUS]     per-CPU write request
//   daddr     in   [CPUS][32] per-CPU word address
//   dstore    in   [CPUS][32] per-CPU write data
//   dwait     out  [CPUS]     per-CPU wait, low only in the completing cycle
//   dload     out  [CPUS][32] per-CPU read data (ramload broadcast)
//   ramREN    out             RAM read enable
//   ramWEN    out             RAM write enable
//   ramaddr   out  [32]       RAM address
//   ramstore  out  [32]       RAM write data
//   ramload   in   [32]       RAM read data
//   ramstate  in   [2]        RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int CPUS = 2,
    parameter int PTRW = $clog2(CPUS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTRW-1:0]   owner_q, owner_d;
    logic [PTRW-1:0]   rr_q,    rr_d;

    logic [CPUS-1:0]   req;
    logic              sel_found;
    logic [PTRW-1:0]   sel_idx;
    logic [PTRW-1:0]   scan_idx;
    logic [PTRW-1:0]   owner_plus1;
    logic              owner_req;
    logic              owner_done;

    assign req = dREN | dWEN;

    // Read data is broadcast; each CPU only consumes it when its dwait is low.
    always_comb begin
        for (int i = 0; i < CPUS; i++) begin
            dload[i] = ramload;
        end
    end

    // Rotating scan starting at rr_q: the first requester found wins, so the
    // most recently served CPU always has the lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < CPUS; k++) begin
            scan_idx = PTRW'((int'(rr_q) + k) % CPUS);
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    assign owner_plus1 = (owner_q == PTRW'(CPUS - 1)) ? '0 : owner_q + PTRW'(1);
    assign owner_req   = req[owner_q];
    // An aborted request never completes, even if the RAM reports ACCESS.
    assign owner_done  = (state_q == GRANT) && owner_req && (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = '1;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    owner_d = sel_idx;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                ramaddr  = daddr[owner_q];
                ramstore = dstore[owner_q];
                if (!owner_req) begin
                    // Requester withdrew: release the RAM without advancing
                    // the round-robin pointer.
                    state_d = IDLE;
                end else begin
                    // Write takes precedence when both enables are set.
                    ramWEN = dWEN[owner_q];
                    ramREN = dREN[owner_q] & ~dWEN[owner_q];
                    if (owner_done) begin
                        dwait[owner_q] = 1'b0;
                        state_d        = IDLE;
                        rr_d           = owner_plus1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
